// File: rtl/c2_enc_pkg.sv
// Shared definitions for the encoder sn-buffer stages: default sample width,
// Q format, history depth, frame size and the shift FSM state encoding.
// Optional build macro: C2_SN_SHIFT_ZERO_FILL_EN (adds the zero-fill state).
package c2_enc_pkg;

    localparam int C2_N       = 32;   // sample word width
    localparam int C2_Q       = 16;   // fraction bits of the sample format
    localparam int C2_M_PITCH = 320;  // history buffer depth in samples
    localparam int C2_N_SAMP  = 80;   // samples per frame, i.e. shift distance
    localparam int C2_RD_LAT  = 2;    // default RAM read latency
    localparam int C2_ADDR_W  = 10;   // sn buffer RAM address width

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
`ifdef C2_SN_SHIFT_ZERO_FILL_EN
        ST_ZF   = 3'd4,
`endif
        ST_DONE = 3'd5
    } state_t;

    // Buffer address of sample index plus an offset; callers keep the sum
    // inside the buffer so the result never wraps.
    function automatic logic [C2_ADDR_W-1:0] sn_addr(
        input logic [C2_ADDR_W-1:0] idx,
        input logic [C2_ADDR_W-1:0] offs
    );
        return idx + offs;
    endfunction

endpackage

// File: rtl/c2_sn_shift_if.sv
// Control handshake and sn buffer RAM port of the history shift stage.
// master: the shift engine (drives the RAM port, reports busy/done).
// slave : the sequencer/RAM side (drives start, returns read data).
interface c2_sn_shift_if #(
    parameter int N = c2_enc_pkg::C2_N
);

    logic                             start;
    logic                             busy;
    logic                             done;
    logic [c2_enc_pkg::C2_ADDR_W-1:0] ram_addr;
    logic [N-1:0]                     ram_wdata;
    logic                             ram_re;
    logic                             ram_we;
    logic [N-1:0]                     ram_rdata;

    modport master (
        input  start,
        input  ram_rdata,
        output busy,
        output done,
        output ram_addr,
        output ram_wdata,
        output ram_re,
        output ram_we
    );

    modport slave (
        output start,
        output ram_rdata,
        input  busy,
        input  done,
        input  ram_addr,
        input  ram_wdata,
        input  ram_re,
        input  ram_we
    );

endinterface

// File: rtl/c2_sn_shift.sv
// sn history shift: copies sn[i+N_SAMP] -> sn[i] for ascending i so the top
// N_SAMP slots are free for the next frame. One read-wait-write sequence per
// sample (2+RD_LAT cycles). All interface outputs come straight from flops.
// Optional build macro: C2_SN_SHIFT_ZERO_FILL_EN -- when defined, the top
// N_SAMP slots are cleared to zero after the copy; otherwise left untouched.
module c2_sn_shift
    import c2_enc_pkg::*;
#(
    parameter int N       = C2_N,
    parameter int M_PITCH = C2_M_PITCH,
    parameter int N_SAMP  = C2_N_SAMP,
    parameter int RD_LAT  = C2_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    c2_sn_shift_if.master bus
);

    localparam int AW = C2_ADDR_W;

    // Index of the last copied sample, last zero-filled slot, shift offset
    // and final wait-counter value (the counter runs 0..RD_LAT-1).
    localparam logic [AW-1:0] LAST_COPY = AW'(M_PITCH - N_SAMP - 1);
    localparam logic [AW-1:0] LAST_SLOT = AW'(M_PITCH - 1);
    localparam logic [AW-1:0] SHIFT_OFS = AW'(N_SAMP);
    localparam logic [2:0]    WAIT_LAST = 3'(RD_LAT - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   i_q,     i_d;
    logic [2:0]      cnt_q,   cnt_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            re_q,    re_d;
    logic            we_q,    we_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [N-1:0]    wdata_q, wdata_d;

    // Next state, then outputs decoded from the next state so that every
    // output flop already matches the state it is registered alongside.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RD;
                    i_d     = '0;
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    // read data is valid on the final wait edge; the write
                    // data register doubles as the capture register
                    state_d = ST_WR;
                    cnt_d   = '0;
                    wdata_d = bus.ram_rdata;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WR: begin
                i_d = i_q + AW'(1);
                if (i_q == LAST_COPY) begin
`ifdef C2_SN_SHIFT_ZERO_FILL_EN
                    state_d = ST_ZF;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_RD;
                end
            end
`ifdef C2_SN_SHIFT_ZERO_FILL_EN
            ST_ZF: begin
                // i continues from M_PITCH-N_SAMP up through the last slot
                i_d = i_q + AW'(1);
                if (i_q == LAST_SLOT) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                // a start still held from the request must drop before
                // another shift can be accepted
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = 1'b0;
        done_d = 1'b0;
        re_d   = 1'b0;
        we_d   = 1'b0;

        case (state_d)
            ST_RD: begin
                busy_d = 1'b1;
                re_d   = 1'b1;
                addr_d = sn_addr(i_d, SHIFT_OFS);
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                re_d   = 1'b1;
            end
            ST_WR: begin
                busy_d = 1'b1;
                we_d   = 1'b1;
                addr_d = i_d;
            end
`ifdef C2_SN_SHIFT_ZERO_FILL_EN
            ST_ZF: begin
                busy_d  = 1'b1;
                we_d    = 1'b1;
                addr_d  = i_d;
                wdata_d = '0;
            end
`endif
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, index, wait counter and registered outputs; reset aborts any
    // shift in progress and silences the RAM port on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            re_q    <= re_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ram_re    = re_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

endmodule

// File: tb/tb_c2_sn_shift.sv
// Bench for c2_sn_shift: three DUTs (RD_LAT 2, 1, 4) each on its own RAM
// model. Expected writes are queued when a shift is started and popped as
// the DUT writes; buffer contents are checked against a reference array.
// Honours C2_SN_SHIFT_ZERO_FILL_EN the same way as the design.
module tb_c2_sn_shift;
    import c2_enc_pkg::*;

    localparam int MP = 320;
    localparam int NS = 80;
    localparam int DW = 32;
`ifdef C2_SN_SHIFT_ZERO_FILL_EN
    localparam bit ZF_ON = 1'b1;
`else
    localparam bit ZF_ON = 1'b0;
`endif
    localparam int ZF_CYC = ZF_ON ? NS : 0;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          init_req = 1'b0;
    logic [2:0]    start_r  = '0;
    logic [2:0]    busy_w, done_w, re_w, we_w;
    logic [9:0]    addr_w  [3];
    logic [DW-1:0] wdata_w [3];

    typedef struct {
        logic [9:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int            g;
        bit            preload;
        bit            hold;
        int            exp_cyc;
        logic [DW-1:0] exp_sn0;
        logic [DW-1:0] exp_sn239;
        logic [DW-1:0] exp_sn240;
    } vec_t;

    wr_t           sbq[$];
    logic [DW-1:0] model [MP];
    int            n_vec = 0;
    int            n_bad = 0;
    int            n_wr  = 0;
    bit            sb_on = 1'b1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        c2_sn_shift_if #(.N(DW)) bus ();
        logic [DW-1:0] mem  [MP];
        logic [DW-1:0] pipe [LAT];

        assign bus.start     = start_r[g];
        assign bus.ram_rdata = pipe[LAT-1];
        assign busy_w[g]     = bus.busy;
        assign done_w[g]     = bus.done;
        assign re_w[g]       = bus.ram_re;
        assign we_w[g]       = bus.ram_we;
        assign addr_w[g]     = bus.ram_addr;
        assign wdata_w[g]    = bus.ram_wdata;

        c2_sn_shift #(.N(DW), .M_PITCH(MP), .N_SAMP(NS), .RD_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );

        // RAM with a strict LAT-deep read pipeline; non-read cycles inject a
        // marker word so a mistimed capture shows up as bad data
        always @(posedge clk) begin
            if (init_req) begin
                for (int k = 0; k < MP; k++) mem[k] <= DW'(k);
            end else if (bus.ram_we && bus.ram_addr < 10'(MP)) begin
                mem[bus.ram_addr] <= bus.ram_wdata;
            end
            pipe[0] <= (bus.ram_re && bus.ram_addr < 10'(MP)) ? mem[bus.ram_addr] : 32'hDEAD_BEEF;
            for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
        end
    end

    function automatic logic [DW-1:0] mem_rd(input int g, input int k);
        case (g)
            0:       return g_inst[0].mem[k];
            1:       return g_inst[1].mem[k];
            default: return g_inst[2].mem[k];
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock, then protocol checks on every DUT and scoreboard pops.
    task automatic cycle();
        wr_t e;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            if (re_w[g] && we_w[g]) begin
                n_bad++;
                $display("FAIL re_we_overlap dut%0d: re=1 we=1, required not both", g);
            end
            if ((re_w[g] || we_w[g]) && addr_w[g] >= 10'(MP)) begin
                n_bad++;
                $display("FAIL addr_range dut%0d: addr=%0d, required < %0d", g, addr_w[g], MP);
            end
            if (we_w[g]) begin
                n_wr++;
                if (sb_on) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_write dut%0d: addr=%0d data=%0d, required no write", g, addr_w[g], wdata_w[g]);
                    end else begin
                        e = sbq.pop_front();
                        check("wr_addr", 64'(addr_w[g]), 64'(e.addr));
                        check("wr_data", 64'(wdata_w[g]), 64'(e.data));
                    end
                end
            end
        end
    endtask

    task automatic preload();
        init_req = 1'b1;
        cycle();
        init_req = 1'b0;
        for (int k = 0; k < MP; k++) model[k] = DW'(k);
    endtask

    // Queue the writes one shift must produce and advance the reference.
    task automatic push_expect();
        wr_t e;
        for (int i = 0; i < MP - NS; i++) begin
            e.addr = 10'(i);
            e.data = model[i + NS];
            sbq.push_back(e);
            model[i] = model[i + NS];
        end
        if (ZF_ON) begin
            for (int k = MP - NS; k < MP; k++) begin
                e.addr = 10'(k);
                e.data = '0;
                sbq.push_back(e);
                model[k] = '0;
            end
        end
    endtask

    task automatic run_shift(input vec_t v);
        int cnt;
        int bad_k;
        if (v.preload) preload();
        n_wr = 0;
        push_expect();
        start_r[v.g] = 1'b1;
        cycle();                        // edge that samples start
        check("busy_after_start", 64'(busy_w[v.g]), 64'd1);
        if (!v.hold) start_r[v.g] = 1'b0;
        cnt = 0;
        while (!done_w[v.g] && cnt < 3000) begin
            cycle();
            cnt++;
        end
        check("done_latency", 64'(cnt), 64'(v.exp_cyc));
        check("busy_in_done", 64'(busy_w[v.g]), 64'd0);
        check("write_count", 64'(n_wr), 64'(MP - NS + ZF_CYC));
        check("sb_drained", 64'(sbq.size()), 64'd0);
        if (v.hold) begin
            repeat (4) cycle();
            check("done_held", 64'(done_w[v.g]), 64'd1);
            check("no_retrigger", 64'(busy_w[v.g]), 64'd0);
            start_r[v.g] = 1'b0;
        end
        cycle();
        check("done_clears", 64'(done_w[v.g]), 64'd0);
        check("sn0", 64'(mem_rd(v.g, 0)), 64'(v.exp_sn0));
        check("sn239", 64'(mem_rd(v.g, 239)), 64'(v.exp_sn239));
        check("sn240", 64'(mem_rd(v.g, 240)), 64'(v.exp_sn240));
        bad_k = -1;
        for (int k = MP - 1; k >= 0; k--) if (mem_rd(v.g, k) !== model[k]) bad_k = k;
        check("buffer_first_bad_index", 64'(signed'(bad_k)), 64'(signed'(-1)));
        sbq.delete();
    endtask

    initial begin
        vec_t vt[5];
        vec_t v;
        int   wr_snap;

        vt[0] = '{0, 1'b1, 1'b0, 960  + ZF_CYC, 80,  319, ZF_ON ? 0 : 240};
        vt[1] = '{1, 1'b1, 1'b0, 720  + ZF_CYC, 80,  319, ZF_ON ? 0 : 240};
        vt[2] = '{2, 1'b1, 1'b0, 1440 + ZF_CYC, 80,  319, ZF_ON ? 0 : 240};
        vt[3] = '{0, 1'b1, 1'b1, 960  + ZF_CYC, 80,  319, ZF_ON ? 0 : 240};
        vt[4] = '{0, 1'b0, 1'b0, 960  + ZF_CYC, 160, ZF_ON ? 0 : 319, ZF_ON ? 0 : 240};

        // reset state
        rst = 1'b1;
        repeat (3) cycle();
        for (int g = 0; g < 3; g++) begin
            check("rst_busy", 64'(busy_w[g]), 64'd0);
            check("rst_done", 64'(done_w[g]), 64'd0);
            check("rst_re_we", 64'({re_w[g], we_w[g]}), 64'd0);
            check("rst_addr", 64'(addr_w[g]), 64'd0);
            check("rst_wdata", 64'(wdata_w[g]), 64'd0);
        end
        rst = 1'b0;
        cycle();

        for (int r = 0; r < 5; r++) run_shift(vt[r]);

        // reset 300 cycles into a shift: aborts with no further writes
        preload();
        sb_on = 1'b0;
        start_r[0] = 1'b1;
        cycle();
        start_r[0] = 1'b0;
        repeat (300) cycle();
        check("busy_before_rst", 64'(busy_w[0]), 64'd1);
        rst = 1'b1;
        cycle();
        check("abort_we", 64'(we_w[0]), 64'd0);
        check("abort_re", 64'(re_w[0]), 64'd0);
        check("abort_busy", 64'(busy_w[0]), 64'd0);
        check("abort_done", 64'(done_w[0]), 64'd0);
        rst = 1'b0;
        wr_snap = n_wr;
        repeat (20) cycle();
        check("no_writes_after_abort", 64'(n_wr - wr_snap), 64'd0);
        check("idle_after_abort", 64'(busy_w[0]), 64'd0);
        sb_on = 1'b1;

        // a fresh start after the abort performs a complete shift
        v = vt[0];
        run_shift(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/c2_sn_shift.md
C2_SN_SHIFT -- requirements
Module: c2_sn_shift

Interface
REQ-001 Parameter N, default 32, sample word width (Q16 fixed point, Q=16 fraction bits).
REQ-002 Parameter M_PITCH, default 320, history buffer depth in samples.
REQ-003 Parameter N_SAMP, default 80, samples per frame (shift distance).
REQ-004 Parameter RD_LAT, default 2, RAM read latency in cycles (address to valid rdata); legal range 1..7.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  level request to shift the buffer once.
REQ-008 busy  output  1  high while a shift is in progress.
REQ-009 done  output  1  high in DONE state; held until start is low.
REQ-010 ram_addr  output  10  sn buffer RAM address.
REQ-011 ram_wdata  output  N  sn buffer RAM write data.
REQ-012 ram_re  output  1  sn buffer RAM read enable.
REQ-013 ram_we  output  1  sn buffer RAM write enable.
REQ-014 ram_rdata  input  N  sn buffer RAM read data, valid RD_LAT cycles after address.

Function
REQ-015 The block SHALL move sn[i+N_SAMP] to sn[i] for i = 0..M_PITCH-N_SAMP-1 in ascending i, leaving sn[M_PITCH-N_SAMP..M_PITCH-1] ready for the frame-load stage.
REQ-016 States SHALL be IDLE, RD, WAIT, WR, ZF, DONE; all outputs registered.
REQ-017 IDLE: start=1 SHALL load i=0 and go to RD; otherwise stay.
REQ-018 RD (1 cycle): ram_addr=i+N_SAMP, ram_re=1, ram_we=0; then WAIT.
REQ-019 WAIT (RD_LAT cycles, counted by a 3-bit counter): ram_re=1, ram_addr held; ram_rdata SHALL be captured on the last WAIT edge; then WR.
REQ-020 WR (1 cycle): ram_addr=i, ram_wdata=captured word, ram_we=1, ram_re=0; i increments; if i was M_PITCH-N_SAMP-1, go to ZF (macro on) or DONE, else RD.
REQ-021 Each sample SHALL take exactly 2+RD_LAT cycles; ram_re and ram_we SHALL never be high together.
REQ-022 DONE: done=1, busy=0, ram_we=0, ram_re=0; return to IDLE when start=0.
REQ-023 busy SHALL be 1 in RD, WAIT, WR, ZF and 0 in IDLE, DONE.
REQ-024 start SHALL be ignored while busy; start held high through DONE SHALL NOT retrigger a second shift.
REQ-025 Index i SHALL be 10 bits unsigned; address sums SHALL not exceed M_PITCH-1.

Reset
REQ-026 rst=1 SHALL force IDLE, i=0, wait counter=0, done=0, busy=0, ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0 at the next edge.
REQ-027 Reset mid-shift SHALL abort with no further RAM writes; buffer contents then undefined; a new start SHALL perform a full shift.

Configuration
REQ-028 Macro C2_SN_SHIFT_ZERO_FILL_EN defined: ZF state writes 0 to addresses M_PITCH-N_SAMP..M_PITCH-1, one per cycle (ram_we=1), then DONE.
REQ-029 Macro undefined: no ZF state; WR of the last sample goes directly to DONE and the top N_SAMP locations are untouched.

Structure
REQ-030 Shared package c2_enc_pkg SHALL hold N, Q, M_PITCH, N_SAMP defaults and the state encoding.
REQ-031 No sub-module; the RAM is external and shared with the frame-load stage via its arbitration.

Verification
REQ-032 RAM preloaded sn[k]=k, RD_LAT=2, macro off, start pulse -> done rises 960 cycles after the start-sampling edge; sn[0]=80, sn[239]=319, sn[240..319] unchanged.
REQ-033 Same with macro on -> done after 1040 cycles; sn[0..239]=80..319, sn[240..319]=0.
REQ-034 RD_LAT=1 and RD_LAT=4 -> totals 720 and 1440 cycles; contents as REQ-032.
REQ-035 rst asserted at cycle 300 -> next cycle ram_we=0, busy=0, done=0; later start -> full correct shift.
REQ-036 start held high throughout -> exactly one shift (240 writes); start low -> IDLE; second pulse -> second shift gives sn[0]=160.
REQ-037 Assertion across all runs: ram_re & ram_we never both 1; ram_addr < 320 whenever either is 1.
